// File: rtl/alu_arbiter_pkg.sv
// Shared ALU definitions: op-code encoding and requester port identifiers.
// Imported by the ALU datapath and by the two-port result arbiter.
package alu_arbiter_pkg;

  typedef enum logic [3:0] {
    OP_ADD  = 4'b0000,
    OP_SUB  = 4'b0001,
    OP_AND  = 4'b0010,
    OP_OR   = 4'b0011,
    OP_XOR  = 4'b0100,
    OP_SLL  = 4'b0101,
    OP_SRL  = 4'b0110,
    OP_SRA  = 4'b0111,
    OP_SLT  = 4'b1000,
    OP_SLTU = 4'b1001
  } alu_op_e;

  typedef logic port_id_t;

  localparam port_id_t PORT0 = 1'b0;
  localparam port_id_t PORT1 = 1'b1;

endpackage

// File: rtl/alu_arbiter_core.sv
// Purely combinational ALU: one operation per cycle on (a, b, op).
// Undefined op codes produce zero; shift amounts use b[4:0] only.
module alu_core
  import alu_arbiter_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [3:0]       op,
  output logic [WIDTH-1:0] result
);

  logic signed [WIDTH-1:0] a_s;
  logic signed [WIDTH-1:0] b_s;
  logic        [4:0]       shamt;

  assign a_s   = a;
  assign b_s   = b;
  assign shamt = b[4:0];

  always_comb begin
    result = '0;
    case (alu_op_e'(op))
      OP_ADD:  result = a + b;
      OP_SUB:  result = a - b;
      OP_AND:  result = a & b;
      OP_OR:   result = a | b;
      OP_XOR:  result = a ^ b;
      OP_SLL:  result = a << shamt;
      OP_SRL:  result = a >> shamt;
      OP_SRA:  result = a_s >>> shamt;
      OP_SLT:  result = {{(WIDTH-1){1'b0}}, (a_s < b_s)};
      OP_SLTU: result = {{(WIDTH-1){1'b0}}, (a < b)};
      default: result = '0;
    endcase
  end

endmodule

// File: rtl/alu_arbiter.sv
// Two requesters share one ALU; a single result register feeds a ready/valid
// consumer. Contention is resolved round-robin against the last granted port.
module alu_arbiter
  import alu_arbiter_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req0_valid,
  output logic             req0_ready,
  input  logic [WIDTH-1:0] req0_a,
  input  logic [WIDTH-1:0] req0_b,
  input  logic [3:0]       req0_op,
  input  logic             req1_valid,
  output logic             req1_ready,
  input  logic [WIDTH-1:0] req1_a,
  input  logic [WIDTH-1:0] req1_b,
  input  logic [3:0]       req1_op,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic             rsp_id,
  output logic [WIDTH-1:0] rsp_result,
  output logic             rsp_zero
);

  logic             slot_free;
  logic             grant0;
  logic             grant1;
  port_id_t         ptr;
  port_id_t         sel;
  logic [WIDTH-1:0] op_a;
  logic [WIDTH-1:0] op_b;
  logic [3:0]       op_code;
  logic [WIDTH-1:0] alu_result;

  // Gated by rst_n so no request is acknowledged while reset is held.
  assign slot_free = rst_n && (!rsp_valid || rsp_ready);
  assign grant0    = slot_free && req0_valid && (!req1_valid || (ptr == PORT1));
  assign grant1    = slot_free && req1_valid && (!req0_valid || (ptr == PORT0));

  assign req0_ready = grant0;
  assign req1_ready = grant1;

  assign sel     = grant1 ? PORT1 : PORT0;
  assign op_a    = grant1 ? req1_a  : req0_a;
  assign op_b    = grant1 ? req1_b  : req0_b;
  assign op_code = grant1 ? req1_op : req0_op;

  alu_core #(
    .WIDTH (WIDTH)
  ) u_alu_core (
    .a      (op_a),
    .b      (op_b),
    .op     (op_code),
    .result (alu_result)
  );

  // Stage p0 -> p1: grant mux + ALU into the held result register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rsp_valid  <= 1'b0;
      rsp_id     <= PORT0;
      rsp_result <= '0;
      ptr        <= PORT1;
    end else if (grant0 || grant1) begin
      rsp_valid  <= 1'b1;
      rsp_id     <= sel;
      rsp_result <= alu_result;
      ptr        <= sel;
    end else if (rsp_ready) begin
      rsp_valid  <= 1'b0;
    end
  end

  assign rsp_zero = (rsp_result == '0);

endmodule
